// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: FSM states and the operand/data select codes.
package mem_stage_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    RDATA = 1'b1
  } state_t;

  localparam logic [1:0] SRC_ALU    = 2'b00;
  localparam logic [1:0] SRC_WDATA  = 2'b01;
  localparam logic [1:0] SRC_SP     = 2'b10;
  localparam logic [1:0] SRC_RSVD   = 2'b11;

  localparam logic [1:0] PUSH_WDATA = 2'b00;
  localparam logic [1:0] PUSH_PC    = 2'b01;
  localparam logic [1:0] PUSH_ALU   = 2'b10;
  localparam logic [1:0] PUSH_FLAGS = 2'b11;

  localparam logic POP_REG = 1'b0;
  localparam logic POP_PC  = 1'b1;

endpackage

// File: rtl/data_ram.sv
// Single-port DEPTH x 8 data RAM, synchronous read, write-first (a write also appears on rdata).
module data_ram #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/stack_mem_unit.sv
// Memory stage: owns SP and data RAM, sequences one-wait-state loads/pops,
// stalls upstream on accepted reads, returns load data or a popped PC.
module stack_mem_unit
  import mem_stage_pkg::*;
#(
  parameter int         DEPTH    = 256,
  parameter logic [7:0] SP_INIT  = 8'hFF,
  parameter logic [7:0] SP_LIMIT = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic       stack_push,
  input  logic       stack_pop,
  input  logic [1:0] mem_src,
  input  logic [1:0] stack_push_mux,
  input  logic       stack_pop_mux,
  input  logic [7:0] alu_result,
  input  logic [7:0] write_data,
  input  logic [7:0] pc_plus1,
  input  logic [3:0] flags,
  output logic [7:0] rdata,
  output logic       rd_valid,
  output logic       pc_load,
  output logic [7:0] pc_target,
  output logic [7:0] sp,
  output logic       stall,
  output logic       stack_fault
);

  state_t     state, state_nxt;
  logic [7:0] sp_q, sp_nxt;
  logic       fault_q, fault_set;
  logic       pop_pc_q, pop_pc_nxt;
  logic       ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_q;
  logic [7:0] mem_addr, push_dat;

  always_comb begin
    case (mem_src)
      SRC_ALU:   mem_addr = alu_result;
      SRC_WDATA: mem_addr = write_data;
      SRC_SP:    mem_addr = sp_q;
      default:   mem_addr = 8'h00;
    endcase
  end

  always_comb begin
    case (stack_push_mux)
      PUSH_WDATA: push_dat = write_data;
      PUSH_PC:    push_dat = pc_plus1;
      PUSH_ALU:   push_dat = alu_result;
      default:    push_dat = {4'b0000, flags};
    endcase
  end

  always_comb begin
    state_nxt  = state;
    sp_nxt     = sp_q;
    pop_pc_nxt = pop_pc_q;
    fault_set  = 1'b0;
    stall      = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = mem_addr;
    ram_wdata  = write_data;
    case (state)
      IDLE: begin
        if (stack_push && stack_pop) begin
          fault_set = 1'b1;
        end else if (stack_push) begin
          if (sp_q < SP_LIMIT) begin
            fault_set = 1'b1;
          end else begin
            ram_we    = 1'b1;
            ram_addr  = sp_q;
            ram_wdata = push_dat;
            sp_nxt    = sp_q - 8'd1;
          end
        end else if (stack_pop) begin
          if (sp_q == SP_INIT) begin
            fault_set = 1'b1;
          end else begin
            ram_addr   = sp_q + 8'd1;
            sp_nxt     = sp_q + 8'd1;
            stall      = 1'b1;
            pop_pc_nxt = stack_pop_mux;
            state_nxt  = RDATA;
          end
        end else if (mem_read) begin
          stall      = 1'b1;
          pop_pc_nxt = POP_REG;
          state_nxt  = RDATA;
        end else if (mem_write) begin
          ram_we = 1'b1;
        end
      end
      // Request inputs still show the held instruction here; ignore them.
      RDATA:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sp_q     <= SP_INIT;
      fault_q  <= 1'b0;
      pop_pc_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      sp_q     <= sp_nxt;
      fault_q  <= fault_q | fault_set;
      pop_pc_q <= pop_pc_nxt;
    end
  end

  data_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // Gating by state means an access aborted by reset never surfaces.
  assign rdata       = (state == RDATA) ? ram_q : 8'h00;
  assign rd_valid    = (state == RDATA) && (pop_pc_q == POP_REG);
  assign pc_load     = (state == RDATA) && (pop_pc_q == POP_PC);
  assign pc_target   = pc_load ? ram_q : 8'h00;
  assign sp          = sp_q;
  assign stack_fault = fault_q;

endmodule

// File: tb/tb_stack_mem_unit.sv
// Directed table-driven bench for stack_mem_unit; one row = one clock cycle of inputs and expected outputs.
module tb_stack_mem_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_read = 0, mem_write = 0, stack_push = 0, stack_pop = 0;
  logic [1:0] mem_src = 0, stack_push_mux = 0;
  logic       stack_pop_mux = 0;
  logic [7:0] alu_result = 0, write_data = 0, pc_plus1 = 0;
  logic [3:0] flags = 0;
  logic [7:0] rdata, pc_target, sp;
  logic       rd_valid, pc_load, stall, stack_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_mem_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .stack_push(stack_push), .stack_pop(stack_pop), .mem_src(mem_src),
    .stack_push_mux(stack_push_mux), .stack_pop_mux(stack_pop_mux),
    .alu_result(alu_result), .write_data(write_data), .pc_plus1(pc_plus1),
    .flags(flags), .rdata(rdata), .rd_valid(rd_valid), .pc_load(pc_load),
    .pc_target(pc_target), .sp(sp), .stall(stall), .stack_fault(stack_fault)
  );

  typedef struct {
    logic       rst, rd, wr, push, pop;
    logic [1:0] msrc, pmux;
    logic       popmux;
    logic [7:0] alu, wd, pc1;
    logic [3:0] flg;
    logic [7:0] e_rdata;
    logic       e_rdv, e_pcl;
    logic [7:0] e_pct, e_sp;
    logic       e_stall, e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, rd, wr, push, pop, input logic [1:0] msrc, pmux, input logic popmux,
    input logic [7:0] alu, wd, pc1, input logic [3:0] flg,
    input logic [7:0] e_rdata, input logic e_rdv, e_pcl, input logic [7:0] e_pct, e_sp,
    input logic e_stall, e_fault);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.push = push; v.pop = pop;
    v.msrc = msrc; v.pmux = pmux; v.popmux = popmux;
    v.alu = alu; v.wd = wd; v.pc1 = pc1; v.flg = flg;
    v.e_rdata = e_rdata; v.e_rdv = e_rdv; v.e_pcl = e_pcl; v.e_pct = e_pct;
    v.e_sp = e_sp; v.e_stall = e_stall; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic run_row(input vec_t v, input int row);
    @(posedge clk);
    #1;
    rst_n = v.rst; mem_read = v.rd; mem_write = v.wr; stack_push = v.push; stack_pop = v.pop;
    mem_src = v.msrc; stack_push_mux = v.pmux; stack_pop_mux = v.popmux;
    alu_result = v.alu; write_data = v.wd; pc_plus1 = v.pc1; flags = v.flg;
    @(negedge clk);
    chk("rdata", row, rdata, v.e_rdata);
    chk("rd_valid", row, {7'd0, rd_valid}, {7'd0, v.e_rdv});
    chk("pc_load", row, {7'd0, pc_load}, {7'd0, v.e_pcl});
    chk("pc_target", row, pc_target, v.e_pct);
    chk("sp", row, sp, v.e_sp);
    chk("stall", row, {7'd0, stall}, {7'd0, v.e_stall});
    chk("stack_fault", row, {7'd0, stack_fault}, {7'd0, v.e_fault});
  endtask

  initial begin
    //              rst rd wr pu po msrc  pmux  pm alu    wd     pc1    flg   e_rd   v  pl pct    sp     st ft
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    // push 3C / pop to register
    vecs.push_back(mk(1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 8'h00, 8'h3C, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFE, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h3C, 1, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    // call / return
    vecs.push_back(mk(1, 0, 0, 1, 0, 2'd0, 2'd1, 0, 8'h00, 8'h00, 8'h42, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 1, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFE, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 1, 8'h00, 8'h00, 8'h00, 4'h0, 8'h42, 0, 1, 8'h42, 8'hFF, 0, 0));
    // store A5 @10, load via write_data address
    vecs.push_back(mk(1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 8'h10, 8'hA5, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 2'd1, 2'd0, 0, 8'h00, 8'h10, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 2'd1, 2'd0, 0, 8'h00, 8'h10, 8'h00, 4'h0, 8'hA5, 1, 0, 8'h00, 8'hFF, 0, 0));
    // push alu, push flags, pop both back (LIFO)
    vecs.push_back(mk(1, 0, 0, 1, 0, 2'd0, 2'd2, 0, 8'h77, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 2'd0, 2'd3, 0, 8'h00, 8'h00, 8'h00, 4'hB, 8'h00, 0, 0, 8'h00, 8'hFE, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFD, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h0B, 1, 0, 8'h00, 8'hFE, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFE, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h77, 1, 0, 8'h00, 8'hFF, 0, 0));
    // read+write together: only the read happens
    vecs.push_back(mk(1, 1, 1, 0, 0, 2'd0, 2'd0, 0, 8'h10, 8'h99, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 2'd0, 2'd0, 0, 8'h10, 8'h99, 8'h00, 4'h0, 8'hA5, 1, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 8'h10, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 8'h10, 8'h00, 8'h00, 4'h0, 8'hA5, 1, 0, 8'h00, 8'hFF, 0, 0));
    // push+pop together is illegal
    vecs.push_back(mk(1, 0, 0, 1, 1, 2'd0, 2'd0, 0, 8'h00, 8'hEE, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 1));
    // underflow
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 1));
    // illegal push+pop leaves SP and RAM alone
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 8'h00, 8'h11, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 2'd0, 2'd0, 0, 8'h00, 8'hEE, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFE, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFE, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFE, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h11, 1, 0, 8'h00, 8'hFF, 0, 1));
    // reset during RDATA of a pop-to-PC
    vecs.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 2'd0, 2'd1, 0, 8'h00, 8'h00, 8'h55, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 1, 8'h00, 8'h00, 8'h55, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFE, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 1, 8'h00, 8'h00, 8'h55, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0));
    // load via mem_src=sp shows FSM is back in IDLE and RAM kept its data
    vecs.push_back(mk(1, 1, 0, 0, 0, 2'd2, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 2'd2, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h55, 1, 0, 8'h00, 8'hFF, 0, 0));

    foreach (vecs[i]) run_row(vecs[i], i);

    // Fill the stack: 128 pushes reach SP_LIMIT, the 129th overflows.
    run_row(mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0), 100);
    for (int k = 0; k < 128; k++) begin
      run_row(mk(1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 8'h00, 8'(k), 8'h00, 4'h0,
                 8'h00, 0, 0, 8'h00, 8'(8'hFF - k), 0, 0), 200 + k);
    end
    run_row(mk(1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 8'h00, 8'hCC, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'h7F, 0, 0), 101);
    run_row(mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'h7F, 0, 1), 102);
    run_row(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'h7F, 1, 1), 103);
    run_row(mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h7F, 1, 0, 8'h00, 8'h80, 0, 1), 104);
    run_row(mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 8'h00, 8'h80, 0, 1), 105);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_mem_unit.md
# stack_mem_unit

Memory-stage consumer of the EX/MEM pipeline register. It takes the registered memory and stack controls (read, write, push, pop, address-source and data-source selects) and does the work they describe:
- owns the 8-bit stack pointer and the data RAM;
- sequences one-wait-state loads and pops;
- raises a stall toward the hazard unit;
- returns load data to write-back, or a popped return address to the PC.

## Interface
Parameters:
- DEPTH, 256: data RAM words (8-bit each); address is 8 bits.
- SP_INIT, 8'hFF: stack pointer reset value (empty-stack position).
- SP_LIMIT, 8'h80: lowest legal push address (full-stack position).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- stack_push  in  1  push request.
- stack_pop  in  1  pop request.
- mem_src  in  2  load/store address select: 00 alu_result, 01 write_data, 10 sp, 11 reserved (address 0).
- stack_push_mux  in  2  push data select: 00 write_data, 01 pc_plus1, 10 alu_result, 11 {4'b0, flags}.
- stack_pop_mux  in  1  pop destination: 0 register (write-back), 1 PC (return).
- alu_result  in  8  address or data from EX.
- write_data  in  8  store data.
- pc_plus1  in  8  return address for call pushes.
- flags  in  4  CCR value for interrupt pushes.
- rdata  out  8  load/pop data.
- rd_valid  out  1  rdata is valid for register write-back.
- pc_load  out  1  one-cycle pulse: load PC from pc_target.
- pc_target  out  8  popped return address.
- sp  out  8  current stack pointer.
- stall  out  1  hold upstream pipeline this cycle.
- stack_fault  out  1  sticky overflow/underflow/illegal-op flag.

## Operation
- FSM states: IDLE, RDATA.
- In IDLE, the first matching rule applies:
  1. stack_push and stack_pop both high: illegal. No RAM or SP change; stack_fault set.
  2. stack_push: if sp < SP_LIMIT (overflow), the push is suppressed and stack_fault is set. Otherwise mem[sp] <= selected push data and sp <= sp-1. Any mem_write in the same cycle is ignored.
  3. stack_pop: if sp == SP_INIT (underflow), the pop is suppressed, stack_fault is set and no stall is raised. Otherwise a read of mem[sp+1] is issued, sp <= sp+1, stall=1, next state RDATA.
  4. mem_read: a read of mem[addr] is issued, stall=1, next state RDATA. A mem_write in the same cycle is ignored.
  5. mem_write: mem[addr] <= write_data. Single cycle, no stall.
- In RDATA:
  - rdata = RAM output.
  - Pop with stack_pop_mux=1: pc_load=1 and pc_target=rdata; rd_valid=0.
  - Otherwise: rd_valid=1.
  - All request inputs are ignored; they are the same held instruction. Next state is IDLE.
- Address arithmetic is 8-bit modulo; sp never wraps, because the limits block it.
- stack_fault is cleared only by reset.
- Outputs not driven in a cycle hold 0 (rdata holds 0 outside RDATA).
- RAM contents are not reset.

## Timing
- Reset values:
  - state IDLE, sp=SP_INIT;
  - rdata=0, rd_valid=0, pc_load=0, pc_target=0;
  - stall=0, stack_fault=0.
- Reset asserted mid-RDATA aborts the access; no pc_load or rd_valid is produced.
- stall is combinational from IDLE plus an accepted read or pop in cycle T. It is deasserted in T+1 (RDATA).
- Load/pop latency: request at T, rdata/rd_valid/pc_load valid in T+1. Throughput is 1 per 2 cycles for loads and pops.
- Store/push: RAM and sp are updated at the T/T+1 edge; a read of the same address at T+1 returns the new data.
- sp output is registered and reflects the update from T+1 onward.

## Structure
- mem_stage_pkg holds:
  - state enum (IDLE, RDATA);
  - mem_src encodings;
  - stack_push_mux encodings;
  - stack_pop_mux encodings.
- One sub-module: data_ram. It is a single-port, synchronous-read, write-first array of DEPTH x 8, and is the only storage instance.
- SP logic, FSM and muxing live in stack_mem_unit.

## Test plan
- Reset, then push write_data=8'h3C with stack_push_mux=00 -> mem[FF]=3C, sp=FE, stall=0. Then pop with stack_pop_mux=0 -> stall=1 at T; rdata=3C and rd_valid=1 at T+1; sp=FF.
- Call/return: push pc_plus1=8'h42 with stack_push_mux=01, then pop with stack_pop_mux=1 -> pc_load=1, pc_target=42 at T+1, rd_valid=0.
- Store 8'hA5 to alu_result=8'h10 with mem_src=00; next cycle load with mem_src=01, write_data=8'h10 -> stall at T, rdata=A5 at T+1.
- Pop at sp=FF -> no stall, sp stays FF, stack_fault=1. After reset, push 128 times then push once more -> 129th is suppressed, sp=7F, stack_fault=1.
- stack_push and stack_pop in the same cycle -> sp unchanged, RAM unchanged, stack_fault=1. mem_read and mem_write together -> only the read occurs.
- rst_n driven low during RDATA of a pop-to-PC -> no pc_load pulse, sp=FF, state IDLE after release.
